// File: rtl/btn_conditioner.sv
// Synchronise, debounce and edge-detect the CTRL/UP/DOWN pushbuttons.
// Define BTN_AUTO_REPEAT_EN to add hold-to-repeat on UP and DOWN.
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic CTRLbtn,
    input  logic UPbtn,
    input  logic DOWNbtn,
    output logic ctrl_pulse,
    output logic up_pulse,
    output logic down_pulse,
    output logic ctrl_held,
    output logic up_held,
    output logic down_held
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // bit 0 = CTRL, bit 1 = UP, bit 2 = DOWN
    logic [2:0]    raw;
    logic [2:0]    s1;
    logic [2:0]    s2;
    logic [2:0]    st;
    logic [2:0]    flip_c;
    logic [2:0]    rise_c;
    logic [CW-1:0] cnt [3];

    assign raw = {DOWNbtn, UPbtn, CTRLbtn};
    assign {down_held, up_held, ctrl_held} = st;

    // accept the synchronised level once it has differed for DEBOUNCE_CYCLES samples
    always_comb begin
        flip_c = '0;
        rise_c = '0;
        for (int i = 0; i < 3; i++) begin
            flip_c[i] = (s2[i] != st[i]) && (cnt[i] == CNT_LAST);
            rise_c[i] = flip_c[i] && s2[i];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1 <= '0;
            s2 <= '0;
            st <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == st[i]) begin
                    cnt[i] <= '0;
                end else if (flip_c[i]) begin
                    st[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) ctrl_pulse <= 1'b0;
        else     ctrl_pulse <= rise_c[0];
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = (RMAX > 0) ? $clog2(RMAX + 1) : 1;

    typedef enum logic [1:0] {R_IDLE, R_DELAY, R_REPEAT} rstate_t;

    // index 0 = UP, index 1 = DOWN
    rstate_t       rstate [2];
    logic [RW-1:0] rcnt   [2];
    logic [1:0]    fall_c;
    logic [1:0]    due_c;
    logic          both_held_c;

    assign both_held_c = st[1] && st[2];

    always_comb begin
        fall_c = '0;
        due_c  = '0;
        for (int j = 0; j < 2; j++) begin
            fall_c[j] = flip_c[j+1] && !s2[j+1];
            due_c[j]  = ((rstate[j] == R_DELAY  && rcnt[j] == RW'(REPEAT_DELAY)) ||
                         (rstate[j] == R_REPEAT && rcnt[j] == RW'(REPEAT_PERIOD))) && !fall_c[j];
        end
    end

    // repeat schedulers keep counting while both are held; only the pulse is gated
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int j = 0; j < 2; j++) begin
                rstate[j] <= R_IDLE;
                rcnt[j]   <= '0;
            end
            up_pulse   <= 1'b0;
            down_pulse <= 1'b0;
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (fall_c[j]) begin
                    rstate[j] <= R_IDLE;
                    rcnt[j]   <= '0;
                end else begin
                    case (rstate[j])
                        R_IDLE: begin
                            if (rise_c[j+1]) begin
                                rstate[j] <= R_DELAY;
                                rcnt[j]   <= RW'(1);
                            end
                        end
                        R_DELAY: begin
                            if (due_c[j]) begin
                                rstate[j] <= R_REPEAT;
                                rcnt[j]   <= RW'(1);
                            end else begin
                                rcnt[j] <= rcnt[j] + 1'b1;
                            end
                        end
                        R_REPEAT: begin
                            if (due_c[j]) rcnt[j] <= RW'(1);
                            else          rcnt[j] <= rcnt[j] + 1'b1;
                        end
                        default: rstate[j] <= R_IDLE;
                    endcase
                end
            end
            up_pulse   <= rise_c[1] || (due_c[0] && !both_held_c);
            down_pulse <= rise_c[2] || (due_c[1] && !both_held_c);
        end
    end
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};

    always_ff @(posedge CLK) begin
        if (RST) begin
            up_pulse   <= 1'b0;
            down_pulse <= 1'b0;
        end else begin
            up_pulse   <= rise_c[1];
            down_pulse <= rise_c[2];
        end
    end
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: per-cycle model comparison plus hand-computed pulse schedules.
module tb_btn_conditioner;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ctrl_b = 1'b0;
    logic up_b = 1'b0;
    logic down_b = 1'b0;
    logic ctrl_pulse, up_pulse, down_pulse, ctrl_held, up_held, down_held;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .CTRLbtn(ctrl_b),
        .UPbtn(up_b),
        .DOWNbtn(down_b),
        .ctrl_pulse(ctrl_pulse),
        .up_pulse(up_pulse),
        .down_pulse(down_pulse),
        .ctrl_held(ctrl_held),
        .up_held(up_held),
        .down_held(down_held)
    );

    always #5 clk = ~clk;

    // Model: a level is accepted when the last D synchronised samples all disagree
    // with it; repeats follow the arithmetic grid measured from the press edge.
    bit hist [3][D+1];
    bit mheld [3];
    bit mpulse [3];
    int pedge [3];

    always @(posedge clk) begin
        bit raw [3];
        bit oldh [3];
        bit newh [3];
        bit flip;
        int dlt;
        cyc++;
        raw[0] = ctrl_b;
        raw[1] = up_b;
        raw[2] = down_b;
        if (rst) begin
            for (int b = 0; b < 3; b++) begin
                for (int k = 0; k <= D; k++) hist[b][k] = 1'b0;
                mheld[b]  = 1'b0;
                mpulse[b] = 1'b0;
                pedge[b]  = 0;
            end
        end else begin
            for (int b = 0; b < 3; b++) begin
                oldh[b] = mheld[b];
                flip = 1'b1;
                for (int k = 1; k <= D; k++) if (hist[b][k] == oldh[b]) flip = 1'b0;
                newh[b] = flip ? !oldh[b] : oldh[b];
            end
            for (int b = 0; b < 3; b++) begin
                mpulse[b] = !oldh[b] && newh[b];
                if (mpulse[b]) pedge[b] = cyc;
`ifdef BTN_AUTO_REPEAT_EN
                if (b != 0 && oldh[b] && newh[b] && !(oldh[1] && oldh[2])) begin
                    dlt = cyc - pedge[b];
                    if (dlt == RD || (dlt > RD && (dlt - RD) % RP == 0)) mpulse[b] = 1'b1;
                end
`endif
                for (int k = D; k >= 1; k--) hist[b][k] = hist[b][k-1];
                hist[b][0] = raw[b];
                mheld[b] = newh[b];
            end
        end
    end

    // per-cycle comparison and pulse logging, away from the active edge
    int ctrl_q[$];
    int up_q[$];
    int down_q[$];

    always @(negedge clk) begin
        logic [5:0] got, want;
        if (cyc >= 1) begin
            got  = {ctrl_pulse, up_pulse, down_pulse, ctrl_held, up_held, down_held};
            want = {mpulse[0], mpulse[1], mpulse[2], mheld[0], mheld[1], mheld[2]};
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL model_cmp cyc=%0d got=%b want=%b", cyc, got, want);
            end
            if (ctrl_pulse) ctrl_q.push_back(cyc);
            if (up_pulse)   up_q.push_back(cyc);
            if (down_pulse) down_q.push_back(cyc);
        end
    end

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic chk(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic chk_q(input string name, input int got[$], input int want[$]);
        chk({name, "_count"}, got.size(), want.size());
        for (int i = 0; i < want.size() && i < got.size(); i++)
            chk($sformatf("%s_edge%0d", name, i), got[i], want[i]);
    endtask

    initial begin
        int exp_ctrl[$];
        int exp_up[$];
        int exp_down[$];
        int all_out;

        exp_ctrl = '{25, 456};
`ifdef BTN_AUTO_REPEAT_EN
        exp_up   = '{110, 156, 166, 169, 172, 175, 178, 181, 184, 187, 190, 193,
                     256, 287, 290, 293, 296, 299, 302, 305, 308, 311, 314};
        exp_down = '{256, 356, 366, 369, 378, 388, 391, 394, 397, 400, 403};
`else
        exp_up   = '{110, 156, 256};
        exp_down = '{256, 356, 378};
`endif

        @(negedge clk);
        goto(3);
        all_out = int'({ctrl_pulse, up_pulse, down_pulse, ctrl_held, up_held, down_held});
        chk("reset_outputs", all_out, 0);
        rst = 1'b0;

        // clean CTRL press sampled at edge 20, held 50 cycles
        goto(19); ctrl_b = 1'b1;
        goto(24); chk("ctrl_held_before", int'(ctrl_held), 0);
        goto(25); chk("ctrl_held_rise", int'(ctrl_held), 1);
        goto(69); ctrl_b = 1'b0;
        goto(74); chk("ctrl_held_still", int'(ctrl_held), 1);
        goto(75); chk("ctrl_held_fall", int'(ctrl_held), 0);

        // UP glitch then steady press; release makes fall coincide with first repeat slot
        goto(100); up_b = 1'b1;
        goto(103); up_b = 1'b0;
        goto(104); up_b = 1'b1;
        goto(114); up_b = 1'b0;

        // UP held 40 cycles
        goto(150); up_b = 1'b1;
        goto(190); up_b = 1'b0;

        // UP and DOWN together, DOWN released first
        goto(250); up_b = 1'b1; down_b = 1'b1;
        goto(280); down_b = 1'b0;
        goto(310); up_b = 1'b0;

        // reset while DOWN is repeating
        goto(350); down_b = 1'b1;
        goto(370); rst = 1'b1;
        goto(371);
        all_out = int'({ctrl_pulse, up_pulse, down_pulse, ctrl_held, up_held, down_held});
        chk("midrun_reset_outputs", all_out, 0);
        goto(372); rst = 1'b0;
        goto(400); down_b = 1'b0;

        // long CTRL hold
        goto(450); ctrl_b = 1'b1;
        goto(550); ctrl_b = 1'b0;
        goto(580);

        chk_q("ctrl_pulses", ctrl_q, exp_ctrl);
        chk_q("up_pulses", up_q, exp_up);
        chk_q("down_pulses", down_q, exp_down);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
